huff_rle_encoder: RTL and testbench
===================================

HUFF_RLE_ENCODER -- requirements
Module: huff_rle_encoder

Interface
REQ-001 SHALL have parameter COEFF_W, default 11: signed quantized coefficient width, legal 8..14.
REQ-002 SHALL have parameter NUM_CH, default 3: channel count (Y/Cb/Cr), legal 1..4; derived CH_W = max(1, clog2(NUM_CH)).
REQ-003 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port coef_valid, input, 1: coefficient beat offered.
REQ-006 SHALL have port coef_ready, output, 1: beat accepted when coef_valid && coef_ready.
REQ-007 SHALL have port coef_data, input, COEFF_W: signed coefficient, zigzag order.
REQ-008 SHALL have port coef_ch, input, CH_W: channel of beat; sampled on block's first beat only.
REQ-009 SHALL have port coef_first, input, 1: beat is index 0 (DC) of a 64-beat block.
REQ-010 SHALL have port dc_clear, input, 1: synchronous clear of all DC predictors (restart interval).
REQ-011 SHALL have port sym_valid, output, 1: symbol available.
REQ-012 SHALL have port sym_ready, input, 1: downstream accepts symbol.
REQ-013 SHALL have port sym_run, output, 4: preceding zero run, 0..15.
REQ-014 SHALL have port sym_size, output, 4: magnitude category.
REQ-015 SHALL have port sym_amp, output, COEFF_W+1: amplitude bits, low sym_size bits valid, upper bits zero.
REQ-016 SHALL have ports sym_is_dc (1), sym_last (1), sym_ch (CH_W), outputs: DC flag, last symbol of block, channel.
REQ-017 SHALL have port proto_err, output, 1: sticky protocol-error flag.

Function
REQ-018 SHALL keep a 6-bit beat index; an accepted beat with coef_first forces index 0, otherwise the index increments; index 63 closes the block.
REQ-019 SHALL keep one COEFF_W-bit DC predictor per channel; DC diff = coef_data - pred[ch], computed at COEFF_W+1 bits; pred[ch] <= coef_data on accept.
REQ-020 SHALL always emit exactly one DC symbol per block: run 0, size = category of diff (0 when diff = 0), sym_is_dc=1.
REQ-021 SHALL define category as bit length of |v|; amp = v if v>0, else (v-1) truncated to size bits.
REQ-022 SHALL count zero AC coefficients; on a nonzero AC coefficient with count >= 16, SHALL first emit one ZRL (run 15, size 0) per 16 zeros, then the coefficient symbol with run = count mod 16.
REQ-023 SHALL drop pending zeros at index 63 and emit EOB (run 0, size 0, sym_last=1); SHALL emit no EOB when index 63 is nonzero, that symbol carrying sym_last=1.
REQ-024 SHALL implement FSM states ACCEPT, ZRL, EOB: ACCEPT->ZRL on nonzero AC with count >= 16; ZRL->ACCEPT when last ZRL accepted and coefficient symbol loaded; ACCEPT->EOB on trailing-zero index 63; EOB->ACCEPT when EOB accepted.
REQ-025 SHALL hold coef_ready low outside ACCEPT and whenever sym_valid && !sym_ready.
REQ-026 SHALL register symbols: sym_valid rises the cycle after the producing beat is accepted; sustained throughput one symbol per cycle with sym_ready high.
REQ-027 SHALL hold all sym_* outputs stable while sym_valid && !sym_ready.
REQ-028 SHALL, on coef_first at nonzero index, set proto_err, discard pending zeros and any ZRL/EOB in progress, and treat the beat as a new DC.
REQ-029 SHALL, on first beat of a stream lacking coef_first after reset, set proto_err and ignore the beat.
REQ-030 SHALL give dc_clear priority over a predictor update in the same cycle: predictors zero, that beat's diff uses the cleared value 0.

Reset
REQ-031 SHALL, while rst=0, force coef_ready=0, sym_valid=0, sym_run=0, sym_size=0, sym_amp=0, sym_is_dc=0, sym_last=0, sym_ch=0, proto_err=0, all predictors 0, index 0, zero count 0, state ACCEPT.
REQ-032 SHALL assert coef_ready the first clk edge after rst deasserts; a block in progress at reset is lost without any symbol.

Verification
REQ-033 SHALL cover: all-zero block ch0 -> DC (0,0,amp 0, is_dc) then EOB (0,0) with sym_last=1, exactly two symbols.
REQ-034 SHALL cover: ch1 DC=50, AC[1]=5 -> DC (0,6,50), AC (0,3,5), EOB; next ch1 block DC=48 -> DC (0,2,amp 1).
REQ-035 SHALL cover: DC=0, AC[20]=-3, rest zero -> DC, ZRL (15,0), (3,2,amp 0), EOB; coef_ready low exactly one cycle for the ZRL.
REQ-036 SHALL cover: AC[63]=1 -> final symbol (14,1,1) after ZRLs, sym_last=1, no EOB.
REQ-037 SHALL cover: sym_ready low random 50% -> symbol sequence identical to sym_ready-high run, outputs stable while stalled.
REQ-038 SHALL cover: coef_first at index 10 -> proto_err=1, new DC symbol; rst=0 mid-block -> outputs at reset values, next block decodes from predictor 0.

Source files
------------

// File: rtl/huff_rle_encoder.sv
// huff_rle_encoder: JPEG-style DC prediction plus AC zero-run/size/amplitude
// symbol generation. One registered symbol slot; ZRL and EOB symbols stall the
// coefficient input while they drain.
module huff_rle_encoder #(
    parameter int COEFF_W = 11,
    parameter int NUM_CH  = 3,
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               coef_valid,
    output logic               coef_ready,
    input  logic [COEFF_W-1:0] coef_data,
    input  logic [CH_W-1:0]    coef_ch,
    input  logic               coef_first,
    input  logic               dc_clear,
    output logic               sym_valid,
    input  logic               sym_ready,
    output logic [3:0]         sym_run,
    output logic [3:0]         sym_size,
    output logic [COEFF_W:0]   sym_amp,
    output logic               sym_is_dc,
    output logic               sym_last,
    output logic [CH_W-1:0]    sym_ch,
    output logic               proto_err
);

    localparam int DW = COEFF_W + 1;

    localparam logic [1:0] S_ACCEPT = 2'd0;
    localparam logic [1:0] S_ZRL    = 2'd1;
    localparam logic [1:0] S_EOB    = 2'd2;

    typedef struct packed {
        logic [3:0]      run;
        logic [3:0]      size;
        logic [DW-1:0]   amp;
        logic            is_dc;
        logic            last;
        logic [CH_W-1:0] ch;
    } sym_t;

    logic [1:0]         state;
    logic               ready_en;
    logic               started;
    logic [5:0]         idx;
    logic [5:0]         zcnt;
    logic [1:0]         zrl_left;
    logic [CH_W-1:0]    ch_r;
    logic [COEFF_W-1:0] pred [2**CH_W];
    sym_t               sym_q, pend_q;
    logic               sym_valid_q, proto_err_q;

    logic               acc, take;
    logic [5:0]         eff_idx;
    logic [COEFF_W-1:0] pred_sel;
    logic [DW-1:0]      val, mag, amp_raw, mask;
    logic [3:0]         val_size;
    sym_t               dc_sym, ac_sym, zrl_sym, eob_sym;

    assign coef_ready = ready_en && (state == S_ACCEPT) && !(sym_valid_q && !sym_ready);

    assign sym_valid = sym_valid_q;
    assign sym_run   = sym_q.run;
    assign sym_size  = sym_q.size;
    assign sym_amp   = sym_q.amp;
    assign sym_is_dc = sym_q.is_dc;
    assign sym_last  = sym_q.last;
    assign sym_ch    = sym_q.ch;
    assign proto_err = proto_err_q;

    // Beat decode: DC difference or AC value, then category and amplitude bits.
    always_comb begin
        acc      = coef_valid && coef_ready;
        take     = acc && (started || coef_first);
        eff_idx  = coef_first ? 6'd0 : idx;
        pred_sel = dc_clear ? '0 : pred[coef_ch];
        if (eff_idx == 6'd0)
            val = {coef_data[COEFF_W-1], coef_data} - {pred_sel[COEFF_W-1], pred_sel};
        else
            val = {coef_data[COEFF_W-1], coef_data};
        mag = val[DW-1] ? (~val + DW'(1)) : val;
        val_size = 4'd0;
        for (int i = 0; i < DW; i++)
            if (mag[i]) val_size = 4'(i + 1);
        amp_raw = val[DW-1] ? (val - DW'(1)) : val;
        mask    = (DW'(1) << val_size) - DW'(1);

        dc_sym       = '0;
        dc_sym.size  = val_size;
        dc_sym.amp   = amp_raw & mask;
        dc_sym.is_dc = 1'b1;
        dc_sym.ch    = coef_ch;

        ac_sym       = '0;
        ac_sym.run   = zcnt[3:0];
        ac_sym.size  = val_size;
        ac_sym.amp   = amp_raw & mask;
        ac_sym.last  = (eff_idx == 6'd63);
        ac_sym.ch    = ch_r;

        zrl_sym      = '0;
        zrl_sym.run  = 4'd15;
        zrl_sym.ch   = ch_r;

        eob_sym      = '0;
        eob_sym.last = 1'b1;
        eob_sym.ch   = ch_r;
    end

    // DC predictors; a clear wins over the update from a DC beat in the same cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 2**CH_W; i++) pred[i] <= '0;
        end else if (dc_clear) begin
            for (int i = 0; i < 2**CH_W; i++) pred[i] <= '0;
        end else if (take && eff_idx == 6'd0) begin
            pred[coef_ch] <= coef_data;
        end
    end

    // Beat sequencing, zero-run counting and the registered symbol slot.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_ACCEPT;
            ready_en    <= 1'b0;
            started     <= 1'b0;
            idx         <= '0;
            zcnt        <= '0;
            zrl_left    <= '0;
            ch_r        <= '0;
            sym_q       <= '0;
            pend_q      <= '0;
            sym_valid_q <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            if (sym_valid_q && sym_ready) sym_valid_q <= 1'b0;
            case (state)
                S_ACCEPT: if (acc) begin
                    if (!take) begin
                        // stream did not open with a DC beat: flag and drop it
                        proto_err_q <= 1'b1;
                    end else begin
                        started <= 1'b1;
                        idx     <= eff_idx + 6'd1;
                        // restart mid-block: pending zeros are discarded via zcnt clear
                        if (coef_first && idx != 6'd0) proto_err_q <= 1'b1;
                        if (eff_idx == 6'd0) begin
                            ch_r        <= coef_ch;
                            zcnt        <= '0;
                            sym_q       <= dc_sym;
                            sym_valid_q <= 1'b1;
                        end else if (coef_data == '0) begin
                            if (eff_idx == 6'd63) begin
                                zcnt        <= '0;
                                sym_q       <= eob_sym;
                                sym_valid_q <= 1'b1;
                                state       <= S_EOB;
                            end else begin
                                zcnt <= zcnt + 6'd1;
                            end
                        end else begin
                            zcnt        <= '0;
                            sym_valid_q <= 1'b1;
                            if (zcnt >= 6'd16) begin
                                sym_q    <= zrl_sym;
                                pend_q   <= ac_sym;
                                zrl_left <= zcnt[5:4] - 2'd1;
                                state    <= S_ZRL;
                            end else begin
                                sym_q <= ac_sym;
                            end
                        end
                    end
                end
                S_ZRL: if (sym_ready) begin
                    // slot holds a ZRL; repeat it or swap in the parked coefficient
                    sym_valid_q <= 1'b1;
                    if (zrl_left != 2'd0) begin
                        zrl_left <= zrl_left - 2'd1;
                    end else begin
                        sym_q <= pend_q;
                        state <= S_ACCEPT;
                    end
                end
                S_EOB: if (sym_ready) state <= S_ACCEPT;
                default: state <= S_ACCEPT;
            endcase
        end
    end

endmodule

// File: tb/tb_huff_rle_encoder.sv
// Scoreboard bench for huff_rle_encoder: directed blocks push hand-computed
// symbols into a queue; a monitor pops and compares on every symbol handshake.
module tb_huff_rle_encoder;

    localparam int COEFF_W = 11;
    localparam int NUM_CH  = 3;
    localparam int CH_W    = 2;
    localparam int SW      = 4 + 4 + COEFF_W + 1 + 1 + 1 + CH_W;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               coef_valid = 1'b0;
    logic               coef_ready;
    logic [COEFF_W-1:0] coef_data = '0;
    logic [CH_W-1:0]    coef_ch = '0;
    logic               coef_first = 1'b0;
    logic               dc_clear = 1'b0;
    logic               sym_valid;
    logic               sym_ready = 1'b1;
    logic [3:0]         sym_run, sym_size;
    logic [COEFF_W:0]   sym_amp;
    logic               sym_is_dc, sym_last;
    logic [CH_W-1:0]    sym_ch;
    logic               proto_err;

    huff_rle_encoder #(.COEFF_W(COEFF_W), .NUM_CH(NUM_CH)) dut (
        .clk(clk), .rst(rst),
        .coef_valid(coef_valid), .coef_ready(coef_ready), .coef_data(coef_data),
        .coef_ch(coef_ch), .coef_first(coef_first), .dc_clear(dc_clear),
        .sym_valid(sym_valid), .sym_ready(sym_ready), .sym_run(sym_run),
        .sym_size(sym_size), .sym_amp(sym_amp), .sym_is_dc(sym_is_dc),
        .sym_last(sym_last), .sym_ch(sym_ch), .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    logic [SW-1:0]             expq [$];
    int                        checks = 0;
    int                        errors = 0;
    int                        low_cnt = 0;
    bit                        rand_mode = 1'b0;
    logic signed [COEFF_W-1:0] blk [64];

    function automatic logic [SW-1:0] e(input int run, input int size, input int amp,
                                        input bit dc, input bit last, input int ch);
        return {4'(run), 4'(size), 12'(amp), dc, last, 2'(ch)};
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0d required %0d", nm, act, exp);
        end
    endtask

    // downstream ready: always high, or a coin flip per cycle when stalling
    always @(posedge clk) begin
        #1;
        sym_ready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // cycles where an offered beat is refused
    always @(negedge clk)
        if (rst && coef_valid && !coef_ready) low_cnt++;

    // monitor: pop/compare on handshake, and hold-check across stalls
    logic [SW-1:0] held;
    bit            stalled = 1'b0;
    always @(negedge clk) begin
        logic [SW-1:0] cur;
        cur = {sym_run, sym_size, sym_amp, sym_is_dc, sym_last, sym_ch};
        if (rst && stalled) begin
            checks++;
            if (!sym_valid || cur !== held) begin
                errors++;
                $display("FAIL stall_hold actual %h/%0b required %h/1", cur, sym_valid, held);
            end
        end
        if (rst && sym_valid && sym_ready) begin
            checks++;
            if (expq.size() == 0) begin
                errors++;
                $display("FAIL sym_unexpected actual %h required none", cur);
            end else begin
                logic [SW-1:0] x;
                x = expq.pop_front();
                if (cur !== x) begin
                    errors++;
                    $display("FAIL sym actual %h required %h", cur, x);
                end
            end
        end
        stalled = rst && sym_valid && !sym_ready;
        held    = cur;
    end

    task automatic beat(input logic [COEFF_W-1:0] d, input bit first, input int ch, input bit clr);
        int n;
        n = 0;
        coef_valid = 1'b1; coef_data = d; coef_first = first;
        coef_ch = 2'(ch); dc_clear = clr;
        forever begin
            @(negedge clk);
            if (coef_ready) break;
            n++;
            if (n > 1000) begin
                checks++; errors++;
                $display("FAIL beat_timeout actual %0d required <1000", n);
                break;
            end
        end
        @(posedge clk); #1;
        coef_valid = 1'b0; coef_first = 1'b0; dc_clear = 1'b0;
    endtask

    task automatic clr_blk();
        for (int i = 0; i < 64; i++) blk[i] = '0;
    endtask

    task automatic send(input int ch, input int n, input bit clr);
        for (int i = 0; i < n; i++) beat(blk[i], i == 0, ch, clr && i == 0);
    endtask

    task automatic drain(input string nm);
        int n;
        n = 0;
        while (expq.size() != 0 && n < 2000) begin
            @(posedge clk); n++;
        end
        #1;
        chk(nm, expq.size(), 0);
    endtask

    initial begin
        // reset state
        repeat (3) @(negedge clk);
        chk("rst_coef_ready", coef_ready, 0);
        chk("rst_sym_valid", sym_valid, 0);
        chk("rst_sym_fields", int'({sym_run, sym_size, sym_amp, sym_is_dc, sym_last, sym_ch}), 0);
        chk("rst_proto_err", proto_err, 0);
        @(posedge clk); #1; rst = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("ready_after_rst", coef_ready, 1);
        @(posedge clk); #1;

        // all-zero block ch0
        clr_blk();
        expq.push_back(e(0, 0, 0, 1, 0, 0));
        expq.push_back(e(0, 0, 0, 0, 1, 0));
        send(0, 64, 0);
        drain("drain_zero_blk");

        // ch1 DC=50 AC1=5, then DC=48
        clr_blk(); blk[0] = 50; blk[1] = 5;
        expq.push_back(e(0, 6, 50, 1, 0, 1));
        expq.push_back(e(0, 3, 5, 0, 0, 1));
        expq.push_back(e(0, 0, 0, 0, 1, 1));
        send(1, 64, 0);
        clr_blk(); blk[0] = 48;
        expq.push_back(e(0, 2, 1, 1, 0, 1));
        expq.push_back(e(0, 0, 0, 0, 1, 1));
        send(1, 64, 0);
        drain("drain_ch1");

        // AC20=-3: one ZRL, one refused cycle
        clr_blk(); blk[20] = -3;
        expq.push_back(e(0, 0, 0, 1, 0, 0));
        expq.push_back(e(15, 0, 0, 0, 0, 0));
        expq.push_back(e(3, 2, 0, 0, 0, 0));
        expq.push_back(e(0, 0, 0, 0, 1, 0));
        low_cnt = 0;
        send(0, 64, 0);
        chk("zrl_ready_low", low_cnt, 1);
        drain("drain_zrl");

        // AC63=1: three ZRLs then last symbol, no EOB
        clr_blk(); blk[63] = 1;
        expq.push_back(e(0, 0, 0, 1, 0, 2));
        repeat (3) expq.push_back(e(15, 0, 0, 0, 0, 2));
        expq.push_back(e(14, 1, 1, 0, 1, 2));
        send(2, 64, 0);
        drain("drain_ac63");

        // random downstream stalls
        rand_mode = 1'b1;
        clr_blk(); blk[0] = -7; blk[1] = 3; blk[2] = -1; blk[40] = 100;
        expq.push_back(e(0, 3, 0, 1, 0, 0));
        expq.push_back(e(0, 2, 3, 0, 0, 0));
        expq.push_back(e(0, 1, 0, 0, 0, 0));
        expq.push_back(e(15, 0, 0, 0, 0, 0));
        expq.push_back(e(15, 0, 0, 0, 0, 0));
        expq.push_back(e(5, 7, 100, 0, 0, 0));
        expq.push_back(e(0, 0, 0, 0, 1, 0));
        send(0, 64, 0);
        drain("drain_stall");
        rand_mode = 1'b0;
        @(posedge clk); #1;

        // extreme DC differences on ch2
        clr_blk(); blk[0] = -1024;
        expq.push_back(e(0, 11, 1023, 1, 0, 2));
        expq.push_back(e(0, 0, 0, 0, 1, 2));
        send(2, 64, 0);
        clr_blk(); blk[0] = 1023;
        expq.push_back(e(0, 11, 2047, 1, 0, 2));
        expq.push_back(e(0, 0, 0, 0, 1, 2));
        send(2, 64, 0);
        drain("drain_extreme");

        // dc_clear on a DC beat: diff from 0, predictors left at 0
        clr_blk(); blk[0] = 5;
        expq.push_back(e(0, 3, 5, 1, 0, 0));
        expq.push_back(e(0, 0, 0, 0, 1, 0));
        send(0, 64, 1);
        expq.push_back(e(0, 3, 5, 1, 0, 0));
        expq.push_back(e(0, 0, 0, 0, 1, 0));
        send(0, 64, 0);
        clr_blk(); blk[0] = 48;
        expq.push_back(e(0, 6, 48, 1, 0, 1));
        expq.push_back(e(0, 0, 0, 0, 1, 1));
        send(1, 64, 0);
        drain("drain_clear");

        // coef_first at index 10
        chk("proto_err_clean", proto_err, 0);
        clr_blk(); blk[0] = 8;
        expq.push_back(e(0, 2, 3, 1, 0, 0));
        send(0, 10, 0);
        clr_blk(); blk[0] = 10;
        expq.push_back(e(0, 2, 2, 1, 0, 0));
        expq.push_back(e(0, 0, 0, 0, 1, 0));
        send(0, 64, 0);
        drain("drain_proto");
        chk("proto_err_restart", proto_err, 1);

        // reset mid-block
        clr_blk(); blk[0] = 20;
        expq.push_back(e(0, 5, 3, 1, 0, 1));
        send(1, 5, 0);
        drain("drain_pre_rst");
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_sym_valid", sym_valid, 0);
        chk("mid_rst_fields", int'({sym_run, sym_size, sym_amp, sym_is_dc, sym_last, sym_ch}), 0);
        chk("mid_rst_proto_err", proto_err, 0);
        chk("mid_rst_ready", coef_ready, 0);
        @(posedge clk); #1; rst = 1'b1;
        @(posedge clk); #1;
        beat(11'd7, 1'b0, 1, 1'b0);
        @(negedge clk);
        chk("proto_err_no_first", proto_err, 1);
        @(posedge clk); #1;
        clr_blk(); blk[0] = 20;
        expq.push_back(e(0, 5, 20, 1, 0, 1));
        expq.push_back(e(0, 0, 0, 0, 1, 1));
        send(1, 64, 0);
        drain("drain_post_rst");

        repeat (5) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
